// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ack port
// and holds one fetched instruction until the pipeline accepts it.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        be_i,
   input  logic [31:0] baddr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   typedef enum logic {
      FETCH = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        drop_q, drop_d;
   logic [31:0] redir_q, redir_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] target;

   assign target = baddr_i & ~32'h3;

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      drop_d  = drop_q;
      redir_d = redir_q;
      valid_d = valid_q;
      pc_d    = pc_q;
      inst_d  = inst_q;

      case (state_q)
         FETCH: begin
            if (imem_ack_i && drop_q) begin
               // Stale fetch returned: go to the newest redirect target.
               drop_d = 1'b0;
               addr_d = be_i ? target : redir_q;
            end else if (imem_ack_i && be_i) begin
               addr_d = target;
            end else if (imem_ack_i) begin
               pc_d    = addr_q;
               inst_d  = imem_rdata_i;
               valid_d = 1'b1;
               addr_d  = addr_q + 32'd4;
               state_d = FULL;
            end else if (be_i) begin
               // Address must stay stable until the ack, so park the target.
               drop_d  = 1'b1;
               redir_d = target;
            end
         end
         FULL: begin
            if (be_i) begin
               valid_d = 1'b0;
               addr_d  = target;
               state_d = FETCH;
            end else if (!stall_i) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         state_q <= FETCH;
         addr_q  <= RESET_PC;
         drop_q  <= 1'b0;
         redir_q <= '0;
         valid_q <= 1'b0;
         pc_q    <= '0;
         inst_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
         redir_q <= redir_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
      end
   end

   assign imem_req_o  = (state_q == FETCH) && !rst;
   assign imem_addr_o = addr_q;
   assign valid_o     = valid_q;
   assign pc_o        = pc_q;
   assign inst_o      = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: random stall/redirect traffic against a variable-latency
// memory, scored against an architectural next-PC stream model.
module tb_if_fetch;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (RESET_PC = 0)
   logic        rst = 1'b1;
   logic        stall_i = 1'b0;
   logic        be_i = 1'b0;
   logic [31:0] baddr_i = '0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;

   // wrap instance (RESET_PC = 0xFFFF_FFFC)
   logic        w_rst = 1'b1;
   logic        w_stall = 1'b0;
   logic        w_be = 1'b0;
   logic [31:0] w_baddr = '0;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack = 1'b0;
   logic [31:0] w_rdata = '0;
   logic        w_valid;
   logic [31:0] w_pc;
   logic [31:0] w_inst;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .be_i(be_i), .baddr_i(baddr_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
      .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o)
   );

   if_fetch #(.RESET_PC(WRAP_PC)) dut_w (
      .clk(clk), .rst(w_rst), .stall_i(w_stall), .be_i(w_be), .baddr_i(w_baddr),
      .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_ack_i(w_ack), .imem_rdata_i(w_rdata),
      .valid_o(w_valid), .pc_o(w_pc), .inst_o(w_inst)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h2408_0005;
   endfunction

   // Reference model: the PC of the next instruction the pipeline should see.
   logic [31:0] sb_q[$];
   logic [31:0] next_pc = 32'h0000_0000;
   bit          expect_gap = 1'b0;
   int          presented = 0;

   // Memory: one outstanding request, ack 1..3 cycles after the request is seen.
   bit          mem_busy = 1'b0;
   int          mem_lat = 0;
   logic [31:0] mem_addr = '0;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         imem_ack_i   = 1'b0;
         imem_rdata_i = $urandom;
         if (rst) begin
            mem_busy = 1'b0;
         end else if (mem_busy) begin
            check("req_held", 32'(imem_req_o), 32'd1);
            check("addr_stable", imem_addr_o, mem_addr);
            mem_lat--;
            if (mem_lat == 0) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = mem_word(mem_addr);
               mem_busy     = 1'b0;
            end
         end else if (imem_req_o) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr_o;
            mem_lat  = $urandom_range(1, 3);
            check("addr_aligned", 32'(imem_addr_o[1:0]), 32'd0);
         end
      end
   end

   // Monitor: compares the presented instruction against the scoreboard.
   initial begin
      logic [31:0] cur;
      bit          prev_valid;
      int          idle;
      cur = '0;
      prev_valid = 1'b0;
      idle = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            check("rst_req", 32'(imem_req_o), 32'd0);
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_pc", pc_o, 32'd0);
            check("rst_inst", inst_o, 32'd0);
            check("rst_addr", imem_addr_o, 32'h0000_0000);
            prev_valid = 1'b0;
            idle = 0;
         end else begin
            check("req_vs_valid", 32'(imem_req_o), 32'(!valid_o));
            if (expect_gap) begin
               check("valid_drop", 32'(valid_o), 32'd0);
               expect_gap = 1'b0;
            end
            if (valid_o) begin
               idle = 0;
               if (!prev_valid) begin
                  if (sb_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_instr actual_pc=%h required=none", pc_o);
                  end else begin
                     cur = sb_q.pop_front();
                     presented++;
                  end
               end
               check("pc_o", pc_o, cur);
               check("inst_o", inst_o, mem_word(cur));
            end else begin
               idle++;
               if (idle > 60) begin
                  checks++;
                  failures++;
                  $display("FAIL fetch_timeout actual=no_valid required=valid_within_60");
                  idle = 0;
               end
            end
            prev_valid = valid_o;
         end
      end
   end

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           t = 32'($urandom_range(0, 32'h3FF));
      return t;
   endfunction

   task automatic model_reset();
      next_pc = 32'h0000_0000;
      sb_q.delete();
      sb_q.push_back(next_pc);
      expect_gap = 1'b0;
   endtask

   initial begin
      model_reset();

      // Directed: RESET_PC at the top of the address space.
      repeat (2) @(negedge clk);
      w_rst = 1'b0;
      @(posedge clk); #1;
      check("w_req_after_rst", 32'(w_req), 32'd1);
      check("w_addr_after_rst", w_addr, WRAP_PC);
      @(negedge clk);
      @(negedge clk);
      w_ack = 1'b1;
      w_rdata = 32'h2408_0005;
      @(negedge clk);
      w_ack = 1'b0;
      w_stall = 1'b1;
      check("w_valid", 32'(w_valid), 32'd1);
      check("w_pc", w_pc, WRAP_PC);
      check("w_inst", w_inst, 32'h2408_0005);
      check("w_req_full", 32'(w_req), 32'd0);
      @(negedge clk);
      w_stall = 1'b0;
      @(posedge clk); #1;
      check("w_valid_consumed", 32'(w_valid), 32'd0);
      check("w_req_wrap", 32'(w_req), 32'd1);
      check("w_addr_wrap", w_addr, 32'h0000_0000);
      @(negedge clk);
      w_rst = 1'b1;
      #1;
      check("w_req_in_rst", 32'(w_req), 32'd0);
      @(posedge clk); #1;
      check("w_addr_reset", w_addr, WRAP_PC);
      check("w_valid_reset", 32'(w_valid), 32'd0);

      // Random traffic on the main instance, with a reset in the middle.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc == 1500 || cyc == 1501) begin
            rst     = 1'b1;
            be_i    = 1'b0;
            stall_i = 1'b0;
            model_reset();
         end else begin
            rst     = 1'b0;
            stall_i = ($urandom_range(0, 99) < 50);
            be_i    = ($urandom_range(0, 99) < 8);
            baddr_i = pick_target();
            if (be_i) begin
               next_pc = baddr_i & ~32'h3;
               sb_q.delete();
               sb_q.push_back(next_pc);
               if (valid_o) expect_gap = 1'b1;
            end else if (valid_o && !stall_i) begin
               next_pc = next_pc + 32'd4;
               sb_q.push_back(next_pc);
               expect_gap = 1'b1;
            end
         end
      end
      @(negedge clk);
      be_i = 1'b0;
      stall_i = 1'b0;
      check("enough_traffic", 32'(presented > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline. Sits directly upstream of the IF/ID register and the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Holds one fetched instruction in an output buffer until the pipeline accepts it.
- Applies branch/jump redirects from decode (be/baddr), discarding stale or in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 00.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  pipeline stall from ctrl; 1 = do not consume the buffered instruction this cycle
be_i  in  1  branch/jump taken, from decode
baddr_i  in  32  redirect target, from decode; bits [1:0] ignored and forced to 00
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch word address; stable while imem_req_o=1 and unacknowledged
imem_ack_i  in  1  one-cycle pulse per request; rdata valid in the same cycle
imem_rdata_i  in  32  fetched instruction word
valid_o  out  1  pc_o/inst_o hold a live instruction
pc_o  out  32  address of the buffered instruction
inst_o  out  32  buffered instruction word

Behaviour:
- State registers:
  - state: FETCH or FULL.
  - addr_q: current request address, drives imem_addr_o.
  - drop_q: discard the next ack.
  - redir_q: pending redirect target.
  - Output buffer: valid_o, pc_o, inst_o.
- Reset (rst=1 at edge):
  - state=FETCH, addr_q=RESET_PC, drop_q=0, redir_q=0.
  - valid_o=0, pc_o=0, inst_o=0.
  - imem_req_o is forced 0 combinationally while rst=1.
  - Reset mid-request abandons the outstanding fetch. Instruction memory shares rst and cancels its own pending ack.
- imem_req_o = (state==FETCH) and not rst. imem_addr_o = addr_q.
- At most one request is outstanding. A new request may be presented the cycle after an ack (back-to-back).
- Memory must not ack in the same cycle req first rises; earliest ack is 1 cycle after req is seen.
- FETCH, per cycle, in priority order:
  1. ack=1 and drop_q=1: rdata discarded; drop_q<=0; addr_q<=(be_i ? baddr_i : redir_q); stay FETCH.
  2. ack=1 and be_i=1: rdata discarded; addr_q<=baddr_i; stay FETCH.
  3. ack=1: pc_o<=addr_q; inst_o<=rdata; valid_o<=1; addr_q<=addr_q+4; go to FULL.
  4. no ack, be_i=1: drop_q<=1; redir_q<=baddr_i; addr_q unchanged (protocol stability); stay FETCH. A later be_i before the ack overwrites redir_q.
  5. otherwise: hold.
- FULL (imem_req_o=0), per cycle:
  - be_i=1, regardless of stall_i: valid_o<=0; addr_q<=baddr_i; go to FETCH. The buffered instruction is killed.
  - stall_i=0: the instruction is consumed this cycle; valid_o<=0; go to FETCH.
  - stall_i=1: hold all outputs bit-stable.
- Latency:
  - Redirect in FULL: request to baddr appears the next cycle.
  - Ack to valid_o: 1 cycle.
  - Steady-state throughput with 1-cycle memory: 1 instruction per 3 cycles.
- Arithmetic: addr_q+4 is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). No alignment check beyond forcing baddr_i[1:0]=00.
- be_i is meaningful only when decode holds a valid instruction; ctrl/decode qualify it. This block acts on every be_i=1.
- valid_o, pc_o and inst_o are registered only; there is no combinational path from imem_* to outputs.

Test Plan:
- Reset release with RESET_PC=0 → req=1, addr=0x0. Ack 2 cycles later with rdata=0x2408_0005 → next cycle valid_o=1, pc_o=0x0, inst_o=0x2408_0005, req=0. With stall_i=0 → following cycle req=1, addr=0x4.
- Buffered instruction at pc 0x4, stall_i=1 for 3 cycles → valid_o/pc_o/inst_o constant, req=0. stall_i drops → valid_o=0 next cycle, req with addr=0x8.
- FULL with stall_i=1, be_i=1, baddr_i=0x43 → next cycle valid_o=0, req=1, addr=0x40.
- Outstanding req at 0x8; be_i=1, baddr_i=0x100 one cycle before ack; ack with rdata=0xDEAD_BEEF → valid_o stays 0, next req addr=0x100. Ack for 0x100 → pc_o=0x100.
- Ack coinciding with be_i=1, baddr_i=0x200 → data discarded, next req 0x200. Pending drop (redir_q=0x100) ack with be_i=1, baddr_i=0x300 → next req 0x300.
- RESET_PC=0xFFFF_FFFC, ack → pc_o=0xFFFF_FFFC, next req addr=0x0. Assert rst while req outstanding → req=0 during rst, addr=RESET_PC after, valid_o=0.
